// File: rtl/msdap_input_loader.sv
// ---------------------------------------------------------------------------
// msdap_input_loader
//
// Serial-input front end of the MSDAP datapath. Deserialises the left and
// right 16-bit words (MSB first, framed by a one-cycle Frame pulse on the MSB)
// and writes them, in order, into the rj memories, the coefficient memories
// and finally the circular xin buffers. It also sequences the datapath:
// compute_enable per new sample, sleep_flag during long silences, and Clear
// while an in-band reset wipes the xin buffers.
//
// Ports:
//   Sclk                       single clock, rising edge
//   Clear_n                    asynchronous active-low reset
//   Frame                      one-cycle pulse coincident with a word's MSB
//   InputL / InputR            serial data, MSB first
//   Reset_in                   synchronous in-band reset request (active high)
//   rj_waddr/we/wdata_L/R      rj memory write port
//   coeff_waddr/we/wdata_L/R   coefficient memory write port
//   xin_waddr/we/wdata_L/R     xin circular buffer write port
//   compute_enable             one-cycle pulse per new sample in WORKING
//   sleep_flag                 high while sleeping on silence
//   Clear                      high while the xin buffers are being wiped
// ---------------------------------------------------------------------------
module msdap_input_loader #(
    parameter int RJ_WORDS    = 16,
    parameter int COEFF_WORDS = 512,
    parameter int SLEEP_COUNT = 800
) (
    input  logic        Sclk,
    input  logic        Clear_n,
    input  logic        Frame,
    input  logic        InputL,
    input  logic        InputR,
    input  logic        Reset_in,
    output logic [3:0]  rj_waddr,
    output logic        rj_we,
    output logic [15:0] rj_wdata_L,
    output logic [15:0] rj_wdata_R,
    output logic [8:0]  coeff_waddr,
    output logic        coeff_we,
    output logic [15:0] coeff_wdata_L,
    output logic [15:0] coeff_wdata_R,
    output logic [7:0]  xin_waddr,
    output logic        xin_we,
    output logic [15:0] xin_wdata_L,
    output logic [15:0] xin_wdata_R,
    output logic        compute_enable,
    output logic        sleep_flag,
    output logic        Clear
);

    localparam int ZW = $clog2(SLEEP_COUNT + 1);
    localparam logic [3:0]    RJ_LAST    = 4'(RJ_WORDS - 1);
    localparam logic [8:0]    COEFF_LAST = 9'(COEFF_WORDS - 1);
    localparam logic [ZW-1:0] SLEEP_MAX  = ZW'(SLEEP_COUNT);
    localparam logic [ZW-1:0] ZERO_ONE   = ZW'(1);

    typedef enum logic [2:0] {
        LOAD_RJ,
        LOAD_COEFF,
        WORKING,
        SLEEPING,
        CLEARING
    } state_t;

    state_t         state;
    logic [14:0]    shift_l;
    logic [14:0]    shift_r;
    logic [3:0]     bit_cnt;
    logic           busy;
    logic [ZW-1:0]  zero_cnt;
    logic           clear_pending;

    logic           frame_ok;
    logic           word_done;
    logic [15:0]    word_l;
    logic [15:0]    word_r;
    logic           word_zero;
    logic           reset_req;

    // Framing is ignored while wiping; a word completes on its 16th bit
    // unless a new Frame arrives in that same cycle and restarts it.
    assign frame_ok  = Frame && (state != CLEARING);
    assign word_done = busy && (bit_cnt == 4'd15) && !frame_ok;
    assign word_l    = {shift_l, InputL};
    assign word_r    = {shift_r, InputR};
    assign word_zero = (word_l == 16'd0) && (word_r == 16'd0);
    // A request that coincides with a completing word is remembered so the
    // word is written first and the wipe starts one cycle later.
    assign reset_req = Reset_in || clear_pending;

    // Shared L/R deserialiser: 15 bits are held, the LSB is taken directly
    // from the input pin in the completing cycle.
    always_ff @(posedge Sclk or negedge Clear_n) begin
        if (!Clear_n) begin
            shift_l <= '0;
            shift_r <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else if (state == CLEARING) begin
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else if (frame_ok) begin
            shift_l <= {14'd0, InputL};
            shift_r <= {14'd0, InputR};
            bit_cnt <= 4'd1;
            busy    <= 1'b1;
        end else if (busy) begin
            shift_l <= {shift_l[13:0], InputL};
            shift_r <= {shift_r[13:0], InputR};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
                busy <= 1'b0;
            end
        end
    end

    // Sequencer. Write strobes are registered on the LSB edge; each address
    // pointer advances on the edge that retires its strobe, so the address
    // presented with a strobe is always the slot being written.
    always_ff @(posedge Sclk or negedge Clear_n) begin
        if (!Clear_n) begin
            state          <= LOAD_RJ;
            rj_waddr       <= '0;
            rj_we          <= 1'b0;
            rj_wdata_L     <= '0;
            rj_wdata_R     <= '0;
            coeff_waddr    <= '0;
            coeff_we       <= 1'b0;
            coeff_wdata_L  <= '0;
            coeff_wdata_R  <= '0;
            xin_waddr      <= '0;
            xin_we         <= 1'b0;
            xin_wdata_L    <= '0;
            xin_wdata_R    <= '0;
            compute_enable <= 1'b0;
            sleep_flag     <= 1'b0;
            Clear          <= 1'b0;
            zero_cnt       <= '0;
            clear_pending  <= 1'b0;
        end else begin
            rj_we          <= 1'b0;
            coeff_we       <= 1'b0;
            xin_we         <= 1'b0;
            compute_enable <= 1'b0;

            if ((state == WORKING || state == SLEEPING) && reset_req && !word_done) begin
                // Start the wipe: first zero write lands at address 0.
                state         <= CLEARING;
                Clear         <= 1'b1;
                sleep_flag    <= 1'b0;
                xin_we        <= 1'b1;
                xin_waddr     <= '0;
                xin_wdata_L   <= '0;
                xin_wdata_R   <= '0;
                zero_cnt      <= '0;
                clear_pending <= 1'b0;
            end else begin
                case (state)
                    LOAD_RJ: begin
                        if (rj_we) begin
                            if (rj_waddr == RJ_LAST) begin
                                rj_waddr <= '0;
                                state    <= LOAD_COEFF;
                            end else begin
                                rj_waddr <= rj_waddr + 4'd1;
                            end
                        end
                        if (word_done) begin
                            rj_we      <= 1'b1;
                            rj_wdata_L <= word_l;
                            rj_wdata_R <= word_r;
                        end
                    end

                    LOAD_COEFF: begin
                        if (coeff_we) begin
                            if (coeff_waddr == COEFF_LAST) begin
                                coeff_waddr <= '0;
                                xin_waddr   <= '0;
                                state       <= WORKING;
                            end else begin
                                coeff_waddr <= coeff_waddr + 9'd1;
                            end
                        end
                        if (word_done) begin
                            coeff_we      <= 1'b1;
                            coeff_wdata_L <= word_l;
                            coeff_wdata_R <= word_r;
                        end
                    end

                    WORKING: begin
                        if (reset_req) begin
                            clear_pending <= 1'b1;
                        end
                        if (xin_we) begin
                            xin_waddr <= xin_waddr + 8'd1;
                        end
                        if (word_done) begin
                            xin_we         <= 1'b1;
                            xin_wdata_L    <= word_l;
                            xin_wdata_R    <= word_r;
                            compute_enable <= 1'b1;
                            if (!word_zero) begin
                                zero_cnt <= '0;
                            end else if (zero_cnt != SLEEP_MAX) begin
                                zero_cnt <= zero_cnt + ZERO_ONE;
                            end
                        end else if (zero_cnt == SLEEP_MAX) begin
                            // The write that saturated the counter has just
                            // gone out; sleep from the following cycle.
                            state      <= SLEEPING;
                            sleep_flag <= 1'b1;
                        end
                    end

                    SLEEPING: begin
                        if (reset_req) begin
                            clear_pending <= 1'b1;
                        end
                        // Silent samples are dropped; the first non-silent
                        // one is stored and the falling sleep_flag restarts
                        // the datapath instead of compute_enable.
                        if (word_done && !word_zero) begin
                            xin_we      <= 1'b1;
                            xin_wdata_L <= word_l;
                            xin_wdata_R <= word_r;
                            sleep_flag  <= 1'b0;
                            zero_cnt    <= '0;
                            state       <= WORKING;
                        end
                    end

                    CLEARING: begin
                        if (xin_waddr == 8'hFF) begin
                            Clear     <= 1'b0;
                            xin_waddr <= '0;
                            zero_cnt  <= '0;
                            state     <= WORKING;
                        end else begin
                            xin_we    <= 1'b1;
                            xin_waddr <= xin_waddr + 8'd1;
                        end
                    end

                    default: begin
                        state <= LOAD_RJ;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msdap_input_loader.sv
// ---------------------------------------------------------------------------
// tb_msdap_input_loader
//
// Self-checking bench for msdap_input_loader. A behavioural model tracks how
// many words have gone to each region, the xin pointer, the silence run and
// the sleep status, and pushes the write it expects for every word sent. A
// monitor pops that queue whenever any write strobe appears and compares
// region, address, data, pulse, Clear and arrival cycle.
// ---------------------------------------------------------------------------
module tb_msdap_input_loader;

    localparam int RJ = 16;
    localparam int CO = 512;
    localparam int SC = 800;

    logic        Sclk = 1'b0;
    logic        Clear_n = 1'b0;
    logic        Frame = 1'b0;
    logic        InputL = 1'b0;
    logic        InputR = 1'b0;
    logic        Reset_in = 1'b0;
    logic [3:0]  rj_waddr;
    logic        rj_we;
    logic [15:0] rj_wdata_L;
    logic [15:0] rj_wdata_R;
    logic [8:0]  coeff_waddr;
    logic        coeff_we;
    logic [15:0] coeff_wdata_L;
    logic [15:0] coeff_wdata_R;
    logic [7:0]  xin_waddr;
    logic        xin_we;
    logic [15:0] xin_wdata_L;
    logic [15:0] xin_wdata_R;
    logic        compute_enable;
    logic        sleep_flag;
    logic        Clear;

    msdap_input_loader #(
        .RJ_WORDS(RJ),
        .COEFF_WORDS(CO),
        .SLEEP_COUNT(SC)
    ) dut (
        .Sclk(Sclk),
        .Clear_n(Clear_n),
        .Frame(Frame),
        .InputL(InputL),
        .InputR(InputR),
        .Reset_in(Reset_in),
        .rj_waddr(rj_waddr),
        .rj_we(rj_we),
        .rj_wdata_L(rj_wdata_L),
        .rj_wdata_R(rj_wdata_R),
        .coeff_waddr(coeff_waddr),
        .coeff_we(coeff_we),
        .coeff_wdata_L(coeff_wdata_L),
        .coeff_wdata_R(coeff_wdata_R),
        .xin_waddr(xin_waddr),
        .xin_we(xin_we),
        .xin_wdata_L(xin_wdata_L),
        .xin_wdata_R(xin_wdata_R),
        .compute_enable(compute_enable),
        .sleep_flag(sleep_flag),
        .Clear(Clear)
    );

    always #5 Sclk = ~Sclk;

    int cyc = 0;
    always @(posedge Sclk) cyc = cyc + 1;

    typedef struct {
        int          kind;
        int          addr;
        logic [15:0] l;
        logic [15:0] r;
        bit          pulse;
        bit          clr;
        bit          sleep_next;
        int          ecyc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    int   m_rj;
    int   m_co;
    int   m_xaddr;
    int   m_zeros;
    bit   m_sleep;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic reportFail(input string name, input string detail);
        total = total + 1;
        bad = bad + 1;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, detail, cyc);
    endtask

    task automatic modelReset();
        m_rj = 0;
        m_co = 0;
        m_xaddr = 0;
        m_zeros = 0;
        m_sleep = 1'b0;
        sbq.delete();
    endtask

    // What a word does depends only on how many words came before it and
    // on the silence history since the last wake or wipe.
    task automatic modelWord(input logic [15:0] l, input logic [15:0] r, input int fc);
        exp_t e;
        e.l = l;
        e.r = r;
        e.pulse = 1'b0;
        e.clr = 1'b0;
        e.sleep_next = 1'b0;
        e.ecyc = fc + 16;
        if (m_rj < RJ) begin
            e.kind = 0;
            e.addr = m_rj;
            m_rj = m_rj + 1;
            sbq.push_back(e);
        end else if (m_co < CO) begin
            e.kind = 1;
            e.addr = m_co;
            m_co = m_co + 1;
            sbq.push_back(e);
        end else if (m_sleep) begin
            if (l != 16'd0 || r != 16'd0) begin
                e.kind = 2;
                e.addr = m_xaddr;
                m_xaddr = (m_xaddr + 1) % 256;
                m_sleep = 1'b0;
                m_zeros = 0;
                sbq.push_back(e);
            end
        end else begin
            e.kind = 2;
            e.addr = m_xaddr;
            e.pulse = 1'b1;
            m_xaddr = (m_xaddr + 1) % 256;
            if (l == 16'd0 && r == 16'd0) begin
                m_zeros = (m_zeros < SC) ? m_zeros + 1 : SC;
            end else begin
                m_zeros = 0;
            end
            if (m_zeros == SC) begin
                m_sleep = 1'b1;
                e.sleep_next = 1'b1;
            end
            sbq.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input int gap);
        @(negedge Sclk);
        modelWord(l, r, cyc);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge Sclk);
            Frame = (i == 0);
            InputL = l[15-i];
            InputR = r[15-i];
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge Sclk);
            Frame = 1'b0;
            InputL = 1'($urandom);
            InputR = 1'($urandom);
        end
    endtask

    task automatic sendPartial(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge Sclk);
            Frame = (i == 0);
            InputL = 1'($urandom);
            InputR = 1'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Sclk);
            Frame = 1'b0;
            InputL = 1'($urandom);
            InputR = 1'($urandom);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rj_waddr"}, 32'(rj_waddr), 0);
        checkOutput({tag, "_rj_we"}, 32'(rj_we), 0);
        checkOutput({tag, "_rj_wdata_L"}, 32'(rj_wdata_L), 0);
        checkOutput({tag, "_rj_wdata_R"}, 32'(rj_wdata_R), 0);
        checkOutput({tag, "_coeff_waddr"}, 32'(coeff_waddr), 0);
        checkOutput({tag, "_coeff_we"}, 32'(coeff_we), 0);
        checkOutput({tag, "_coeff_wdata_L"}, 32'(coeff_wdata_L), 0);
        checkOutput({tag, "_coeff_wdata_R"}, 32'(coeff_wdata_R), 0);
        checkOutput({tag, "_xin_waddr"}, 32'(xin_waddr), 0);
        checkOutput({tag, "_xin_we"}, 32'(xin_we), 0);
        checkOutput({tag, "_xin_wdata_L"}, 32'(xin_wdata_L), 0);
        checkOutput({tag, "_xin_wdata_R"}, 32'(xin_wdata_R), 0);
        checkOutput({tag, "_compute_enable"}, 32'(compute_enable), 0);
        checkOutput({tag, "_sleep_flag"}, 32'(sleep_flag), 0);
        checkOutput({tag, "_Clear"}, 32'(Clear), 0);
    endtask

    // Wipe: 256 zero writes expected one per cycle from the cycle after the
    // request; framed noise during the wipe must be ignored.
    task automatic doInBandReset();
        exp_t e;
        int   c;
        @(negedge Sclk);
        Frame = 1'b0;
        Reset_in = 1'b1;
        c = cyc;
        for (int i = 0; i < 256; i++) begin
            e.kind = 2;
            e.addr = i;
            e.l = 16'd0;
            e.r = 16'd0;
            e.pulse = 1'b0;
            e.clr = 1'b1;
            e.sleep_next = 1'b0;
            e.ecyc = c + 1 + i;
            sbq.push_back(e);
        end
        m_xaddr = 0;
        m_zeros = 0;
        m_sleep = 1'b0;
        @(negedge Sclk);
        Reset_in = 1'b0;
        for (int i = 0; i < 250; i++) begin
            @(negedge Sclk);
            Frame = ($urandom_range(0, 7) == 0);
            InputL = 1'($urandom);
            InputR = 1'($urandom);
        end
        idle(10);
    endtask

    // Scoreboard monitor.
    bit          chk_sleep = 1'b0;
    bit          exp_sleep = 1'b0;
    int          nwe;
    int          kact;
    int          aact;
    logic [15:0] dl;
    logic [15:0] dr;
    exp_t        me;

    always @(negedge Sclk) begin
        if (Clear_n) begin
            if (chk_sleep) checkOutput("sleep_after_write", 32'(sleep_flag), 32'(exp_sleep));
            chk_sleep = 1'b0;
            nwe = int'(rj_we) + int'(coeff_we) + int'(xin_we);
            if (nwe > 1) begin
                checkOutput("strobes_per_cycle", nwe, 1);
            end else if (nwe == 1) begin
                if (rj_we) begin
                    kact = 0; aact = int'(rj_waddr); dl = rj_wdata_L; dr = rj_wdata_R;
                end else if (coeff_we) begin
                    kact = 1; aact = int'(coeff_waddr); dl = coeff_wdata_L; dr = coeff_wdata_R;
                end else begin
                    kact = 2; aact = int'(xin_waddr); dl = xin_wdata_L; dr = xin_wdata_R;
                end
                if (sbq.size() == 0) begin
                    reportFail("unexpected_write",
                        $sformatf("got region=%0d addr=%0d L=%0h R=%0h, want no write", kact, aact, dl, dr));
                end else begin
                    me = sbq.pop_front();
                    checkOutput("write_region", kact, me.kind);
                    checkOutput("write_addr", aact, me.addr);
                    checkOutput("write_data_L", 32'(dl), 32'(me.l));
                    checkOutput("write_data_R", 32'(dr), 32'(me.r));
                    checkOutput("compute_enable", 32'(compute_enable), 32'(me.pulse));
                    checkOutput("Clear_at_write", 32'(Clear), 32'(me.clr));
                    checkOutput("sleep_at_write", 32'(sleep_flag), 0);
                    checkOutput("write_cycle", cyc, me.ecyc);
                    chk_sleep = 1'b1;
                    exp_sleep = me.sleep_next;
                end
            end else begin
                checkOutput("idle_compute_enable", 32'(compute_enable), 0);
                checkOutput("idle_Clear", 32'(Clear), 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    logic [15:0] a;
    logic [15:0] b;

    initial begin
        modelReset();
        Clear_n = 1'b0;
        idle(3);
        checkAllZero("reset");
        @(negedge Sclk);
        Clear_n = 1'b1;

        // rj load with the reference pattern, back to back.
        for (int i = 0; i < RJ; i++) applyStimulus(16'(i + 1), 16'(16'h0101 + i), 0);

        // Coefficients: random data, occasional gaps.
        for (int i = 0; i < CO; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            applyStimulus(a, b, (i % 7 == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        // 260 constant samples wrap the xin pointer.
        for (int i = 0; i < 260; i++) applyStimulus(16'h1234, 16'h1234, 0);

        // Random samples with frequent silence and random gaps.
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            applyStimulus(a, b, int'($urandom_range(0, 2)));
        end
        applyStimulus(16'h0001, 16'h0000, 0);

        // Sleep: 800 silent samples, 5 dropped, then a wake sample.
        for (int i = 0; i < SC; i++) applyStimulus(16'd0, 16'd0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(16'd0, 16'd0, 0);
        idle(4);
        checkOutput("sleep_flag_while_asleep", 32'(sleep_flag), 1);
        applyStimulus(16'h0007, 16'h0000, 0);
        idle(3);
        checkOutput("sleep_flag_after_wake", 32'(sleep_flag), 0);

        // Silence run broken one short of the threshold.
        for (int i = 0; i < SC - 1; i++) applyStimulus(16'd0, 16'd0, 0);
        applyStimulus(16'h0001, 16'h0000, 0);
        for (int i = 0; i < 10; i++) applyStimulus(16'd0, 16'd0, 0);
        idle(3);
        checkOutput("sleep_flag_run_broken", 32'(sleep_flag), 0);

        // In-band reset after 40 samples, then more samples from address 0.
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            applyStimulus(a, b, int'($urandom_range(0, 1)));
        end
        idle(3);
        doInBandReset();
        for (int i = 0; i < 5; i++) begin
            a = 16'($urandom) | 16'h0001;
            b = 16'($urandom);
            applyStimulus(a, b, 0);
        end
        idle(3);

        // Asynchronous reset while working.
        checkOutput("queue_before_reset1", sbq.size(), 0);
        @(negedge Sclk);
        #2 Clear_n = 1'b0;
        #1 checkAllZero("async_working");
        @(negedge Sclk);
        Clear_n = 1'b1;
        modelReset();

        // Reload, resync mid-word in LOAD_COEFF, then reset mid-LOAD_COEFF.
        for (int i = 0; i < RJ; i++) begin
            a = 16'($urandom) | 16'h8000;
            b = 16'($urandom);
            applyStimulus(a, b, 0);
        end
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom) | 16'h0100;
            b = 16'($urandom);
            applyStimulus(a, b, 0);
        end
        sendPartial(8);
        applyStimulus(16'hA5C3, 16'h3C5A, 0);
        idle(3);
        sendPartial(9);
        checkOutput("queue_before_reset2", sbq.size(), 0);
        #2 Clear_n = 1'b0;
        #1 checkAllZero("async_load_coeff");
        @(negedge Sclk);
        Clear_n = 1'b1;
        modelReset();
        applyStimulus(16'hBEEF, 16'h0F0F, 0);
        idle(20);

        for (int k = 0; k < 50 && sbq.size() != 0; k++) @(negedge Sclk);
        checkOutput("scoreboard_drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
